// File: rtl/pattern_mode_ctrl.sv
// pattern_mode_ctrl
//   Debounced, frame-synchronous display-pattern mode controller. Raw board
//   switches are synchronised and debounced into a stable request. The
//   registered `mode` only moves on a frame_start pulse, so a pattern never
//   tears mid-frame. An auto-cycle (slideshow) state steps through the valid
//   modes every AUTO_FRAMES frames.
//
// Ports
//   clk          in   pixel/system clock, sole clock
//   rst          in   synchronous active-high reset
//   sw           in   [MODE_BITS-1:0] raw asynchronous mode switches
//   auto_en      in   raw asynchronous auto-cycle enable switch
//   frame_start  in   one-clock pulse at start of each frame (clk domain)
//   mode         out  [MODE_BITS-1:0] current pattern mode, registered
//   mode_changed out  one-clock pulse in the first cycle `mode` shows a new value
//   pending      out  manual request differs from `mode`, awaiting frame_start

module pattern_mode_ctrl #(
  parameter int MODE_BITS       = 2,
  parameter int NUM_MODES       = 4,
  parameter int DEBOUNCE_CYCLES = 250000,
  parameter int AUTO_FRAMES     = 60,
  parameter int DEFAULT_MODE    = 0
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [MODE_BITS-1:0] sw,
  input  logic                 auto_en,
  input  logic                 frame_start,
  output logic [MODE_BITS-1:0] mode,
  output logic                 mode_changed,
  output logic                 pending
);

  localparam int DB_W = $clog2(DEBOUNCE_CYCLES);
  localparam int FC_W = $clog2(AUTO_FRAMES) + 1;

  localparam logic [DB_W-1:0]      DB_MAX    = DB_W'(DEBOUNCE_CYCLES - 1);
  localparam logic [FC_W-1:0]      FC_LAST   = FC_W'(AUTO_FRAMES - 1);
  localparam logic [MODE_BITS-1:0] MODE_DEF  = MODE_BITS'(DEFAULT_MODE);
  localparam logic [MODE_BITS-1:0] MODE_LAST = MODE_BITS'(NUM_MODES - 1);
  // One extra bit so NUM_MODES == 2**MODE_BITS is representable.
  localparam logic [MODE_BITS:0]   MODE_CNT  = (MODE_BITS + 1)'(NUM_MODES);

  localparam logic [0:0] ST_MANUAL = 1'b0;
  localparam logic [0:0] ST_AUTO   = 1'b1;

  // Synchronisers
  logic [MODE_BITS-1:0] sw_s1, sw_s2;
  logic                 ae_s1, ae_s2;

  // Debouncer
  logic [MODE_BITS-1:0] cand;
  logic [DB_W-1:0]      db_cnt;
  logic [MODE_BITS-1:0] stable;

  // Mode FSM
  logic [0:0]           state, state_nxt;
  logic [FC_W-1:0]      fcnt, fcnt_nxt;
  logic [MODE_BITS-1:0] mode_nxt;
  logic                 pending_nxt;
  logic [MODE_BITS-1:0] target;

  // NOTE: sequential state uses non-blocking assignments so every flop
  // samples the pre-edge value of its neighbours, like real hardware.
  // The reset is synchronous: it is just the highest-priority branch.
  always_ff @(posedge clk) begin
    if (rst) begin
      sw_s1  <= '0;
      sw_s2  <= '0;
      ae_s1  <= 1'b0;
      ae_s2  <= 1'b0;
      cand   <= MODE_DEF;
      db_cnt <= '0;
      stable <= MODE_DEF;
    end else begin
      sw_s1 <= sw;
      sw_s2 <= sw_s1;
      ae_s1 <= auto_en;
      ae_s2 <= ae_s1;
      if (sw_s2 != cand) begin
        // Any change restarts the stability window.
        cand   <= sw_s2;
        db_cnt <= '0;
      end else if (db_cnt == DB_MAX) begin
        stable <= cand;
      end else begin
        db_cnt <= db_cnt + 1'b1;
      end
    end
  end

  // Out-of-range switch codes fall back to the default pattern.
  assign target = ({1'b0, stable} < MODE_CNT) ? stable : MODE_DEF;

  // NOTE: every output of this block gets a default first so no path leaves
  // a variable unassigned, which would otherwise infer a latch.
  always_comb begin
    state_nxt = state;
    fcnt_nxt  = fcnt;
    mode_nxt  = mode;
    case (state)
      ST_MANUAL: begin
        if (frame_start && (target != mode)) mode_nxt = target;
        if (ae_s2) begin
          state_nxt = ST_AUTO;
          fcnt_nxt  = '0;
        end
      end
      default: begin // ST_AUTO
        if (frame_start) begin
          if (fcnt == FC_LAST) begin
            fcnt_nxt = '0;
            // Wrap at NUM_MODES, not at 2**MODE_BITS.
            mode_nxt = (mode == MODE_LAST) ? '0 : mode + 1'b1;
          end else begin
            fcnt_nxt = fcnt + 1'b1;
          end
        end
        if (!ae_s2) state_nxt = ST_MANUAL;
      end
    endcase
    // Compared against the post-edge mode so pending drops in the same cycle
    // the request is applied; forced low whenever the next state is AUTO.
    pending_nxt = (state_nxt == ST_MANUAL) && (target != mode_nxt);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state        <= ST_MANUAL;
      fcnt         <= '0;
      mode         <= MODE_DEF;
      mode_changed <= 1'b0;
      pending      <= 1'b0;
    end else begin
      state        <= state_nxt;
      fcnt         <= fcnt_nxt;
      mode         <= mode_nxt;
      mode_changed <= (mode_nxt != mode);
      pending      <= pending_nxt;
    end
  end

endmodule

// File: tb/tb_pattern_mode_ctrl.sv
// Directed bench for pattern_mode_ctrl with a small expected-output queue.
module tb_pattern_mode_ctrl;

  logic       clk = 1'b0;
  logic       rst;
  logic [1:0] sw;
  logic       auto_en;
  logic       frame_start;
  logic [1:0] mode;
  logic       mode_changed;
  logic       pending;

  int checks = 0;
  int errors = 0;

  typedef struct {
    string      tag;
    logic [1:0] mode;
    logic       mc;
    logic       pend;
  } exp_t;

  exp_t exp_q[$];

  pattern_mode_ctrl #(
    .MODE_BITS      (2),
    .NUM_MODES      (3),
    .DEBOUNCE_CYCLES(4),
    .AUTO_FRAMES    (3),
    .DEFAULT_MODE   (0)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .sw          (sw),
    .auto_en     (auto_en),
    .frame_start (frame_start),
    .mode        (mode),
    .mode_changed(mode_changed),
    .pending     (pending)
  );

  always #5 clk = ~clk;

  // Inputs change and outputs are sampled 1 time unit after the rising edge.
  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic push_exp(input string tag, input logic [1:0] m,
                          input logic mc, input logic p);
    exp_t e;
    e.tag = tag; e.mode = m; e.mc = mc; e.pend = p;
    exp_q.push_back(e);
  endtask

  task automatic check_out();
    exp_t e;
    if (exp_q.size() == 0) begin
      checks++;
      errors++;
      $error("FAIL scoreboard_empty observed=%0d expected=1", exp_q.size());
      return;
    end
    e = exp_q.pop_front();
    checks++;
    assert (mode === e.mode) else begin
      errors++;
      $error("FAIL %s.mode observed=%0d expected=%0d", e.tag, mode, e.mode);
    end
    checks++;
    assert (mode_changed === e.mc) else begin
      errors++;
      $error("FAIL %s.mode_changed observed=%0b expected=%0b", e.tag, mode_changed, e.mc);
    end
    checks++;
    assert (pending === e.pend) else begin
      errors++;
      $error("FAIL %s.pending observed=%0b expected=%0b", e.tag, pending, e.pend);
    end
  endtask

  // Expect-then-observe helpers.
  task automatic settle(input string tag, input int n, input logic [1:0] m,
                        input logic mc, input logic p);
    push_exp(tag, m, mc, p);
    tick(n);
    check_out();
  endtask

  task automatic frame(input string tag, input logic [1:0] m,
                       input logic mc, input logic p);
    push_exp(tag, m, mc, p);
    frame_start = 1'b1;
    tick(1);
    frame_start = 1'b0;
    check_out();
  endtask

  // mode may only move on an edge where frame_start or rst was sampled high.
  always @(posedge clk) begin
    logic [1:0] m_before;
    logic       allowed;
    m_before = mode;
    allowed  = frame_start | rst;
    #1;
    if (mode !== m_before) begin
      checks++;
      assert (allowed === 1'b1) else begin
        errors++;
        $error("FAIL mode_moved_off_frame observed=%0d->%0d expected=hold", m_before, mode);
      end
    end
  end

  int mc_seen = 0;
  always @(negedge clk) if (mode_changed === 1'b1) mc_seen++;

  initial begin
    logic [1:0] am;
    int         ac;
    int         mc_exp;

    rst = 1'b1; sw = 2'b10; auto_en = 1'b0; frame_start = 1'b0;
    mc_exp = 0;

    // 1. Reset with sw=2 held; request appears 8 clocks after release.
    settle("reset", 2, 2'd0, 1'b0, 1'b0);
    rst = 1'b0;
    settle("reset_pending", 8, 2'd0, 1'b0, 1'b1);

    // 2. Manual change to mode 1.
    sw = 2'b01;
    settle("manual_pre", 10, 2'd0, 1'b0, 1'b1);
    frame("manual_apply", 2'd1, 1'b1, 1'b0); mc_exp++;
    settle("manual_post", 1, 2'd1, 1'b0, 1'b0);

    // 3. Two-clock glitch to 2 must be rejected.
    sw = 2'b10;
    tick(2);
    sw = 2'b01;
    settle("glitch_hold", 8, 2'd1, 1'b0, 1'b0);
    frame("glitch_frame", 2'd1, 1'b0, 1'b0);

    // 4. Out-of-range code 3 maps to the default mode 0.
    sw = 2'b11;
    settle("oor_pre", 10, 2'd1, 1'b0, 1'b1);
    frame("oor_apply", 2'd0, 1'b1, 1'b0); mc_exp++;

    // 5. Auto-cycle from mode 1 across the wrap.
    sw = 2'b01;
    settle("auto_setup_pre", 10, 2'd0, 1'b0, 1'b1);
    frame("auto_setup", 2'd1, 1'b1, 1'b0); mc_exp++;
    auto_en = 1'b1;
    settle("auto_enter", 4, 2'd1, 1'b0, 1'b0);
    am = 2'd1; ac = 0;
    for (int i = 1; i <= 7; i++) begin
      logic chg;
      chg = 1'b0;
      if (ac == 2) begin
        ac  = 0;
        am  = (am == 2'd2) ? 2'd0 : am + 2'd1;
        chg = 1'b1;
        mc_exp++;
      end else begin
        ac++;
      end
      frame($sformatf("auto_f%0d", i), am, chg, 1'b0);
      settle($sformatf("auto_gap%0d", i), 2, am, 1'b0, 1'b0);
    end
    auto_en = 1'b0;
    settle("auto_exit", 4, 2'd0, 1'b0, 1'b1);
    frame("auto_exit_apply", 2'd1, 1'b1, 1'b0); mc_exp++;

    // 6. Reset collides with frame_start while a request is pending.
    sw = 2'b10;
    settle("rst_mid_pre", 10, 2'd1, 1'b0, 1'b1);
    push_exp("rst_mid", 2'd0, 1'b0, 1'b0);
    rst = 1'b1; frame_start = 1'b1;
    tick(1);
    rst = 1'b0; frame_start = 1'b0;
    check_out();
    // Pending rises again only if the FSM came back in MANUAL.
    settle("rst_mid_manual", 9, 2'd0, 1'b0, 1'b1);
    frame("rst_mid_apply", 2'd2, 1'b1, 1'b0); mc_exp++;
    settle("final_idle", 3, 2'd2, 1'b0, 1'b0);

    checks++;
    assert (mc_seen == mc_exp) else begin
      errors++;
      $error("FAIL mode_changed_count observed=%0d expected=%0d", mc_seen, mc_exp);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout observed=running expected=finished");
    $fatal(1, "timeout");
  end

endmodule
